// File: rtl/bram_mem_responder_pkg.sv
// Shared definitions for the BRAM memory responder: FSM state encoding,
// default timing constants and a small elaboration-time helper.
package bram_mem_responder_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_READ    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_REFRESH = 3'd4
    } state_e;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_RD_LATENCY = 4;
    localparam int DEF_WR_LATENCY = 3;
    localparam int DEF_REF_CYCLES = 6;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bram_byte_we.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered
// (synchronous) read port, written so synthesis maps it onto block RAM.
module bram_byte_we #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Read-first port: rdata_q reflects the word as it was before any write
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_mem_responder.sv
// Memory responder: zero-fills the RAM after reset, then serves one read,
// write or refresh at a time with a fixed busy window per transaction type.
module bram_mem_responder
    import bram_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int WR_LATENCY = DEF_WR_LATENCY,
    parameter int REF_CYCLES = DEF_REF_CYCLES
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        read_a,
    input  logic        read_b,
    input  logic        write,
    input  logic        refresh,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  mask,
    output logic [31:0] dout_a,
    output logic        busy,
    output logic        mem_initialized,
    output logic        fail
);

    localparam int MAX_LAT = max3(RD_LATENCY, WR_LATENCY, REF_CYCLES);
    localparam int CNT_W   = $clog2(MAX_LAT);

    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_LATENCY - 1);
    localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(REF_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  mem_init_q, mem_init_d;
    logic                  fail_q, fail_d;
    logic [31:0]           dout_q, dout_d;

    logic [ADDR_WIDTH-1:0] word_q;
    logic [31:0]           din_q;
    logic [3:0]            mask_q;
    logic                  oor_q;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] req_word;
    logic                  req_oor;

    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    // read_b is deliberately inert; the low address bits are assumed aligned
    logic unused_inputs;
    assign unused_inputs = ^{read_b, addr[1:0]};

    assign req_word = addr[ADDR_WIDTH+1:2];
    assign req_oor  = (addr >> (ADDR_WIDTH + 2)) != 32'd0;

    bram_byte_we #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            init_cnt_q <= '0;
            mem_init_q <= 1'b0;
            fail_q     <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_cnt_q <= init_cnt_d;
            mem_init_q <= mem_init_d;
            fail_q     <= fail_d;
            dout_q     <= dout_d;
        end
    end

    // Request operands are pure data and only meaningful after an accept
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= req_word;
            din_q  <= din;
            mask_q <= mask;
            oor_q  <= req_oor;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_cnt_d = init_cnt_q;
        mem_init_d = mem_init_q;
        fail_d     = fail_q;
        dout_d     = dout_q;
        accept     = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 4'h0;
        ram_addr   = word_q;
        ram_wdata  = din_q;

        unique case (state_q)
            ST_INIT: begin
                ram_en    = 1'b1;
                ram_we    = 4'hF;
                ram_addr  = init_cnt_q;
                ram_wdata = '0;
                if (&init_cnt_q) begin
                    state_d    = ST_IDLE;
                    mem_init_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (read_a) begin
                    accept  = 1'b1;
                    state_d = ST_READ;
                    cnt_d   = RD_LOAD;
                    fail_d  = fail_q | req_oor;
                end else if (write) begin
                    accept  = 1'b1;
                    state_d = ST_WRITE;
                    cnt_d   = WR_LOAD;
                    fail_d  = fail_q | req_oor;
                end else if (refresh) begin
                    accept  = 1'b1;
                    state_d = ST_REFRESH;
                    cnt_d   = REF_LOAD;
                end
            end
            ST_READ: begin
                // RAM output is valid from the second busy cycle onward
                ram_en = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    dout_d  = oor_q ? '0 : ram_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (!oor_q) begin
                        ram_en = 1'b1;
                        ram_we = ~mask_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_REFRESH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign busy            = (state_q != ST_IDLE);
    assign mem_initialized = mem_init_q;
    assign fail            = fail_q;
    assign dout_a          = dout_q;

endmodule

// File: tb/tb_bram_mem_responder.sv
// Randomized bench for bram_mem_responder: a transaction-level model of the
// memory and expected outputs is compared against the DUT on every cycle.
module tb_bram_mem_responder;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int RDL   = 4;
    localparam int WRL   = 3;
    localparam int RFL   = 6;

    logic        clk = 1'b0;
    logic        rst_x;
    logic        read_a, read_b, write, refresh;
    logic [31:0] addr, din, dout_a;
    logic [3:0]  mask;
    logic        busy, mem_initialized, fail;

    always #5 clk = ~clk;

    bram_mem_responder #(
        .ADDR_WIDTH(AW),
        .RD_LATENCY(RDL),
        .WR_LATENCY(WRL),
        .REF_CYCLES(RFL)
    ) dut (
        .clk            (clk),
        .rst_x          (rst_x),
        .read_a         (read_a),
        .read_b         (read_b),
        .write          (write),
        .refresh        (refresh),
        .addr           (addr),
        .din            (din),
        .mask           (mask),
        .dout_a         (dout_a),
        .busy           (busy),
        .mem_initialized(mem_initialized),
        .fail           (fail)
    );

    int          n_pass = 0;
    int          n_tot  = 0;
    bit          chk_en = 1'b0;
    logic [31:0] mdl_mem [DEPTH];
    logic        exp_busy, exp_init, exp_fail;
    logic [31:0] exp_dout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    endtask

    function automatic bit m_oor(input logic [31:0] a);
        return a >= 32'(4 * DEPTH);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic model_reset();
        exp_busy = 1'b1;
        exp_init = 1'b0;
        exp_fail = 1'b0;
        exp_dout = '0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    endtask

    task automatic clear_req();
        read_a  = 1'b0;
        write   = 1'b0;
        refresh = 1'b0;
    endtask

    // Every output is checked on each falling edge while enabled
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("mem_initialized", 32'(mem_initialized), 32'(exp_init));
            chk("fail", 32'(fail), 32'(exp_fail));
            chk("dout_a", dout_a, exp_dout);
        end
    end

    // Waits n cycles while throwing random junk at every input; counts busy cycles
    task automatic noisy_wait(input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (busy) hi++;
            read_a  = 1'($urandom);
            write   = 1'($urandom);
            refresh = 1'($urandom);
            read_b  = 1'($urandom);
            addr    = $urandom;
            din     = $urandom;
            mask    = 4'($urandom);
            @(posedge clk);
        end
    endtask

    task automatic txn(input logic ra, input logic wr, input logic rf,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       output int hi);
        int lat;
        bit oor;
        int idx;
        @(negedge clk);
        read_a  = ra;
        write   = wr;
        refresh = rf;
        read_b  = 1'($urandom);
        addr    = a;
        din     = d;
        mask    = m;
        @(posedge clk);
        #1;
        oor = m_oor(a);
        idx = m_idx(a);
        lat = ra ? RDL : (wr ? WRL : RFL);
        exp_busy = 1'b1;
        if ((ra || wr) && oor) exp_fail = 1'b1;
        noisy_wait(lat, hi);
        #1;
        clear_req();
        exp_busy = 1'b0;
        if (ra) begin
            exp_dout = oor ? 32'h0 : mdl_mem[idx];
        end else if (wr && !oor) begin
            for (int i = 0; i < 4; i++)
                if (!m[i]) mdl_mem[idx][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    initial begin
        int hi;
        logic ra, wr, rf;
        logic [31:0] a;

        rst_x  = 1'b0;
        clear_req();
        read_b = 1'b0;
        addr   = '0;
        din    = '0;
        mask   = '0;
        model_reset();
        chk_en = 1'b1;

        // Reset release and init sweep
        repeat (3) @(posedge clk);
        #1 rst_x = 1'b1;
        noisy_wait(DEPTH, hi);
        #1;
        clear_req();
        exp_busy = 1'b0;
        exp_init = 1'b1;
        chk("init_busy_cycles", 32'(hi), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            txn(1'b1, 1'b0, 1'b0, 32'(i * 4), 32'h0, 4'h0, hi);
            chk("init_word_zero", dout_a, 32'h0);
        end

        // Full write then read back
        txn(1'b0, 1'b1, 1'b0, 32'h10, 32'hA1B2C3D4, 4'h0, hi);
        chk("write_busy_cycles", 32'(hi), 32'd3);
        txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, hi);
        chk("read_busy_cycles", 32'(hi), 32'd4);
        chk("read_full_word", dout_a, 32'hA1B2C3D4);

        // Byte-masked writes
        txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0000EEFF, 4'hC, hi);
        txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, hi);
        chk("mask_c_merge", dout_a, 32'hA1B2EEFF);
        txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h99000000, 4'h7, hi);
        txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, hi);
        chk("mask_7_merge", dout_a, 32'h99B2EEFF);

        // Simultaneous requests: read wins, the rest are dropped
        txn(1'b1, 1'b1, 1'b1, 32'h10, 32'h12345678, 4'h0, hi);
        chk("prio_busy_cycles", 32'(hi), 32'd4);
        chk("prio_read_data", dout_a, 32'h99B2EEFF);
        txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, hi);
        chk("prio_mem_unchanged", dout_a, 32'h99B2EEFF);

        // Out-of-range accesses
        chk("fail_before_oor", 32'(fail), 32'd0);
        txn(1'b0, 1'b1, 1'b0, 32'h40, 32'hFFFFFFFF, 4'h0, hi);
        chk("oor_write_busy", 32'(hi), 32'd3);
        chk("oor_fail_set", 32'(fail), 32'd1);
        txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0, hi);
        chk("oor_read_zero", dout_a, 32'h0);
        txn(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, hi);
        chk("oor_alias_untouched", dout_a, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            ra = ($urandom_range(0, 2) == 0);
            wr = 1'($urandom);
            rf = ($urandom_range(0, 3) == 0);
            if (!ra && !wr && !rf) wr = 1'b1;
            a = {26'h0, 4'($urandom), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) a[31:6] = 26'($urandom_range(1, 1000));
            txn(ra, wr, rf, a, $urandom, 4'($urandom), hi);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                read_b = 1'($urandom);
            end
        end

        // Reset in the middle of a write
        @(negedge clk);
        write = 1'b1;
        addr  = 32'h8;
        din   = 32'hDEADBEEF;
        mask  = 4'h0;
        @(posedge clk);
        #1;
        clear_req();
        exp_busy = 1'b1;
        @(posedge clk);
        #1;
        rst_x = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_busy_high", 32'(busy), 32'd1);
        chk("rst_init_low", 32'(mem_initialized), 32'd0);
        chk("rst_fail_low", 32'(fail), 32'd0);
        @(posedge clk);
        #1 rst_x = 1'b1;
        noisy_wait(DEPTH, hi);
        #1;
        clear_req();
        exp_busy = 1'b0;
        exp_init = 1'b1;
        chk("reinit_busy_cycles", 32'(hi), 32'd16);
        txn(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 4'h0, hi);
        chk("rst_target_word_zero", dout_a, 32'h0);
        txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, hi);
        chk("rst_other_word_zero", dout_a, 32'h0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/bram_mem_responder.md
BRAM_MEM_RESPONDER -- requirements
Module: bram_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: word-address bits; depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter RD_LATENCY, default 4: busy-high cycles per read, minimum 2.
REQ-003 SHALL have parameter WR_LATENCY, default 3: busy-high cycles per write, minimum 2.
REQ-004 SHALL have parameter REF_CYCLES, default 6: busy-high cycles per refresh, minimum 2.
REQ-005 Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_x  in  1  reset, asynchronous, active-low.
- read_a  in  1  read request.
- read_b  in  1  secondary read request; ignored, never starts a transaction.
- write  in  1  write request.
- refresh  in  1  refresh request.
- addr  in  32  byte address.
- din  in  32  write data.
- mask  in  4  per-byte mask; bit=1 means that byte is NOT written.
- dout_a  out  32  read data.
- busy  out  1  transaction or init in progress.
- mem_initialized  out  1  init sweep finished.
- fail  out  1  sticky out-of-range error.

Function
REQ-006 States SHALL be INIT, IDLE, READ, WRITE, REFRESH.
REQ-007 INIT SHALL write 0 to every word, one word per cycle, busy=1, then enter IDLE and set mem_initialized=1; mem_initialized is never cleared except by reset.
REQ-008 Requests SHALL be sampled only in IDLE; priority read_a > write > refresh; lower-priority simultaneous requests are dropped.
REQ-009 On an accepted request at edge t, addr, din and mask SHALL be captured at t, and busy SHALL be 1 from t+1 for exactly the state's latency (RD_LATENCY, WR_LATENCY or REF_CYCLES) cycles, then 0.
REQ-010 Word index SHALL be addr[ADDR_WIDTH+1:2]; addr[1:0] ignored (requester aligns).
REQ-011 WRITE SHALL update only bytes with mask bit 0 (byte i = din[8i+7:8i]), committed on the final busy cycle.
REQ-012 READ SHALL load dout_a with the addressed word no later than the cycle busy falls; dout_a holds until the next read completes.
REQ-013 REFRESH SHALL not access the memory array.
REQ-014 Out-of-range access (addr[31:ADDR_WIDTH+2] != 0): fail SHALL be set, write discarded, read returns 32'h0; busy timing unchanged.
REQ-015 A request held high on return to IDLE SHALL start a new transaction.
REQ-016 Request inputs SHALL have no effect during INIT or while busy=1.
REQ-017 Any request asserted in the same cycle as a write commit SHALL observe the written data.

Reset
REQ-018 Asserting rst_x low at any time, including mid-transaction or mid-INIT, SHALL immediately force state INIT, busy=1, mem_initialized=0, fail=0, dout_a=0, init counter=0.
REQ-019 After rst_x release, the init sweep SHALL restart from word 0; prior contents are lost.

Structure
REQ-020 State encoding and default latency constants SHALL live in the shared define package.
REQ-021 Storage SHALL be one sub-module, bram_byte_we (single-port, 4 byte write enables, synchronous read) so it infers block RAM.
REQ-022 Latency SHALL be counted by one shared down-counter wide enough for the largest parameter.

Verification
REQ-023 Reset release with ADDR_WIDTH=4 -> busy=1 for 16 cycles, then busy=0, mem_initialized=1; read of every word returns 0.
REQ-024 write addr=0x10 din=0xA1B2C3D4 mask=0x0, then read_a addr=0x10 -> busy high exactly 3 then 4 cycles; dout_a=0xA1B2C3D4.
REQ-025 write addr=0x10 din=0x0000EEFF mask=0xC over 0xA1B2C3D4 -> read returns 0xA1B2EEFF; second write mask=0x7 din=0x99000000 -> 0x99B2EEFF.
REQ-026 read_a, write, refresh asserted together in IDLE -> read performed, busy 4 cycles, memory unchanged, refresh not executed.
REQ-027 ADDR_WIDTH=4, write addr=0x40 -> fail=1, busy 3 cycles, memory unchanged; read addr=0x40 -> dout_a=0.
REQ-028 rst_x low during WRITE busy cycle 2 -> busy stays 1, mem_initialized=0, fail=0; after sweep the target word reads 0.
